// File: rtl/spi_byte_shifter.sv
// SPI host serial stage: shifts TX bytes onto sd_o and assembles sampled sd_i
// bits into RX bytes, one to four lanes per step (std / dual / quad).
module spi_byte_shifter #(
    parameter int unsigned ByteW = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic [1:0]       speed_i,
    input  logic             tx_en_i,
    input  logic             rx_en_i,
    input  logic             tx_valid_i,
    input  logic [ByteW-1:0] tx_data_i,
    output logic             tx_ready_o,
    output logic             rx_valid_o,
    output logic [ByteW-1:0] rx_data_o,
    input  logic             rx_ready_i,
    input  logic             sample_en_i,
    input  logic             shift_en_i,
    output logic             ready_o,
    input  logic [3:0]       sd_i,
    output logic [3:0]       sd_o,
    output logic [3:0]       sd_oe_o
);
    localparam int unsigned CntW  = $clog2(ByteW + 1);
    localparam int unsigned LaneW = 4;

    localparam logic [1:0] SpeedDual = 2'd1;
    localparam logic [1:0] SpeedQuad = 2'd2;

    typedef enum logic [1:0] {
        EMPTY,
        ACTIVE,
        RX_PEND
    } state_e;

    state_e            state_q, state_d;
    logic [ByteW-1:0]  sr_q, sr_d;
    logic [ByteW-1:0]  rx_data_q, rx_data_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LaneW-1:0]  sample_q, sample_d;
    logic [1:0]        speed_q, speed_d;
    logic [LaneW-1:0]  ins;
    logic [ByteW-1:0]  shifted;

    function automatic logic [LaneW-1:0] lane_mask(input logic [1:0] speed);
        case (speed)
            SpeedDual: lane_mask = 4'b0011;
            SpeedQuad: lane_mask = 4'b1111;
            default:   lane_mask = 4'b0001;
        endcase
    endfunction

    function automatic logic [CntW-1:0] step_count(input logic [1:0] speed);
        case (speed)
            SpeedDual: step_count = CntW'(ByteW / 2);
            SpeedQuad: step_count = CntW'(ByteW / 4);
            default:   step_count = CntW'(ByteW);
        endcase
    endfunction

    // Std mode listens on sd_i[1] (MISO) while it drives sd_o[0] (MOSI).
    function automatic logic [LaneW-1:0] pick_lanes(input logic [1:0]       speed,
                                                    input logic [LaneW-1:0] sd);
        case (speed)
            SpeedDual: pick_lanes = {2'b00, sd[1:0]};
            SpeedQuad: pick_lanes = sd;
            default:   pick_lanes = {3'b000, sd[1]};
        endcase
    endfunction

    function automatic logic [ByteW-1:0] shift_in(input logic [1:0]       speed,
                                                  input logic [ByteW-1:0] sr,
                                                  input logic [LaneW-1:0] lanes);
        case (speed)
            SpeedDual: shift_in = {sr[ByteW-3:0], lanes[1:0]};
            SpeedQuad: shift_in = {sr[ByteW-5:0], lanes[3:0]};
            default:   shift_in = {sr[ByteW-2:0], lanes[0]};
        endcase
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= EMPTY;
            sr_q      <= '0;
            rx_data_q <= '0;
            cnt_q     <= '0;
            sample_q  <= '0;
            speed_q   <= '0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            rx_data_q <= rx_data_d;
            cnt_q     <= cnt_d;
            sample_q  <= sample_d;
            speed_q   <= speed_d;
        end
    end

    // A same-cycle sample bypasses sample_q so the fresh lanes go straight in.
    always_comb begin
        ins     = sample_en_i ? pick_lanes(speed_q, sd_i) : sample_q;
        shifted = shift_in(speed_q, sr_q, ins);
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        rx_data_d = rx_data_q;
        cnt_d     = cnt_q;
        sample_d  = sample_q;
        speed_d   = speed_q;

        case (state_q)
            EMPTY: begin
                if (tx_en_i) begin
                    if (tx_valid_i) begin
                        state_d = ACTIVE;
                        sr_d    = tx_data_i;
                        speed_d = speed_i;
                        cnt_d   = step_count(speed_i);
                    end
                end else if (rx_en_i) begin
                    state_d = ACTIVE;
                    sr_d    = '0;
                    speed_d = speed_i;
                    cnt_d   = step_count(speed_i);
                end
            end
            ACTIVE: begin
                if (sample_en_i) begin
                    sample_d = pick_lanes(speed_q, sd_i);
                end
                if (shift_en_i) begin
                    sr_d  = shifted;
                    cnt_d = cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        if (rx_en_i) begin
                            rx_data_d = shifted;
                            state_d   = RX_PEND;
                        end else begin
                            state_d = EMPTY;
                        end
                    end
                end
            end
            RX_PEND: begin
                if (rx_ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Clear wins over load, shift and a pending RX byte.
        if (clr_i) begin
            state_d   = EMPTY;
            sr_d      = '0;
            cnt_d     = '0;
            sample_d  = '0;
            rx_data_d = '0;
        end
    end

    // Output decode.
    always_comb begin
        tx_ready_o = rst_ni && (state_q == EMPTY) && tx_en_i && !clr_i;
        ready_o    = (state_q == ACTIVE);
        rx_valid_o = (state_q == RX_PEND);
        rx_data_o  = rx_valid_o ? rx_data_q : '0;
        sd_oe_o    = (ready_o && tx_en_i) ? lane_mask(speed_q) : '0;
        case (speed_q)
            SpeedDual: sd_o = {2'b00, sr_q[ByteW-1 -: 2]};
            SpeedQuad: sd_o = sr_q[ByteW-1 -: 4];
            default:   sd_o = {3'b000, sr_q[ByteW-1]};
        endcase
    end

endmodule

// File: tb/tb_spi_byte_shifter.sv
// Randomised scoreboard bench for spi_byte_shifter: the driver pushes expected
// lane/RX values from a bit-arithmetic model, a negedge monitor pops and compares.
module tb_spi_byte_shifter;
    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       clr_i, tx_en_i, rx_en_i, tx_valid_i, rx_ready_i;
    logic       sample_en_i, shift_en_i;
    logic [1:0] speed_i;
    logic [7:0] tx_data_i;
    logic       tx_ready_o, rx_valid_o, ready_o;
    logic [7:0] rx_data_o;
    logic [3:0] sd_i, sd_o, sd_oe_o;

    int n_tests = 0;
    int n_fail  = 0;

    logic [3:0] exp_sd_q[$];
    logic [3:0] exp_oe_q[$];
    logic [7:0] exp_rx_q[$];
    logic [3:0] sd_plan[8];

    spi_byte_shifter #(.ByteW(8)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .speed_i(speed_i),
        .tx_en_i(tx_en_i), .rx_en_i(rx_en_i), .tx_valid_i(tx_valid_i),
        .tx_data_i(tx_data_i), .tx_ready_o(tx_ready_o), .rx_valid_o(rx_valid_o),
        .rx_data_o(rx_data_o), .rx_ready_i(rx_ready_i), .sample_en_i(sample_en_i),
        .shift_en_i(shift_en_i), .ready_o(ready_o), .sd_i(sd_i), .sd_o(sd_o),
        .sd_oe_o(sd_oe_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lanes_of(input logic [1:0] sp);
        return (sp == 2'd1) ? 2 : (sp == 2'd2) ? 4 : 1;
    endfunction

    // Value carried in from sd_i for one step: MISO only in std mode.
    function automatic int lane_val(input logic [3:0] sv, input int l);
        if (l == 1) return int'(sv[1]);
        if (l == 2) return int'(sv[1:0]);
        return int'(sv);
    endfunction

    // Monitor: compares lanes at each accepted shift and RX bytes at each handshake.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (ready_o && shift_en_i) begin
                if (exp_sd_q.size() == 0) begin
                    check("unexpected_shift", 32'(sd_o), 32'hFFFF_FFFF);
                end else begin
                    check("sd_o", 32'(sd_o), 32'(exp_sd_q.pop_front()));
                    check("sd_oe_o", 32'(sd_oe_o), 32'(exp_oe_q.pop_front()));
                end
            end
            if (rx_valid_o) begin
                check("rx_valid_expected", 32'(exp_rx_q.size() > 0), 32'd1);
                if (rx_ready_i && exp_rx_q.size() > 0)
                    check("rx_data_o", 32'(rx_data_o), 32'(exp_rx_q.pop_front()));
            end else begin
                check("rx_data_idle_zero", 32'(rx_data_o), 32'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    // One sample/shift pair, either in the same cycle or sample first then shift.
    task automatic do_step(input logic [3:0] sv);
        int gap;
        gap = $urandom_range(0, 2);
        sd_i = sv;
        sample_en_i = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
            idle(1);
            sample_en_i = 1'b0;
            sd_i = 4'($urandom);
            idle(gap);
        end
        shift_en_i = 1'b1;
        idle(1);
        sample_en_i = 1'b0;
        shift_en_i  = 1'b0;
        sd_i = 4'($urandom);
    endtask

    task automatic start_byte(input bit te, input bit re, input logic [1:0] sp,
                              input logic [7:0] data);
        int t;
        t = 0;
        tx_en_i = te;
        rx_en_i = re;
        speed_i = sp;
        tx_data_i = data;
        tx_valid_i = te;
        do begin
            idle(1);
            t++;
        end while (!ready_o && t < 20);
        if (!ready_o) check("load_timeout", 32'(ready_o), 32'd1);
        tx_valid_i = 1'b0;
        tx_data_i = 8'($urandom);
        speed_i = 2'($urandom);
    endtask

    // Pushes expected lanes for steps [first,last) and accumulates the RX byte.
    task automatic do_steps(input bit te, input logic [7:0] data, input int l,
                            input int first, input int last, inout logic [7:0] rx);
        int txv;
        txv = te ? int'(data) : 0;
        for (int k = first; k < last; k++) begin
            exp_sd_q.push_back(4'((txv >> (8 - l * (k + 1))) & ((1 << l) - 1)));
            exp_oe_q.push_back(te ? 4'((1 << l) - 1) : 4'h0);
            do_step(sd_plan[k]);
            rx = 8'((rx << l) | lane_val(sd_plan[k], l));
        end
    endtask

    task automatic end_byte(input bit te, input bit re, input logic [7:0] rx, input int stall);
        logic [7:0] held;
        if (re) begin
            exp_rx_q.push_back(rx);
            tx_valid_i = te;
            held = rx_data_o;
            for (int i = 0; i < stall; i++) begin
                @(negedge clk_i);
                check("stall_ready_o", 32'(ready_o), 32'd0);
                check("stall_tx_ready_o", 32'(tx_ready_o), 32'd0);
                check("stall_rx_data_stable", 32'(rx_data_o), 32'(held));
                idle(1);
            end
            rx_ready_i = 1'b1;
            idle(1);
            rx_ready_i = 1'b0;
            tx_valid_i = 1'b0;
        end else begin
            @(negedge clk_i);
            check("tx_ready_after_byte", 32'(tx_ready_o), 32'(te));
            idle(1);
        end
        tx_en_i = 1'b0;
        rx_en_i = 1'b0;
    endtask

    task automatic run_byte(input bit te, input bit re, input logic [1:0] sp,
                            input logic [7:0] data, input int stall);
        logic [7:0] rx;
        int l;
        rx = 8'h00;
        l = lanes_of(sp);
        start_byte(te, re, sp, data);
        do_steps(te, data, l, 0, 8 / l, rx);
        end_byte(te, re, rx, stall);
    endtask

    task automatic rand_plan();
        for (int i = 0; i < 8; i++) sd_plan[i] = 4'($urandom);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_ready_o"}, 32'(tx_ready_o), 32'd0);
        check({tag, "_rx_valid_o"}, 32'(rx_valid_o), 32'd0);
        check({tag, "_ready_o"}, 32'(ready_o), 32'd0);
        check({tag, "_sd_o"}, 32'(sd_o), 32'd0);
        check({tag, "_sd_oe_o"}, 32'(sd_oe_o), 32'd0);
        check({tag, "_rx_data_o"}, 32'(rx_data_o), 32'd0);
    endtask

    initial begin
        logic [7:0] rx;
        bit te, re;
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx;
        bit te, re;
        rst_ni = 1'b0; clr_i = 1'b0; tx_en_i = 1'b1; rx_en_i = 1'b1;
        tx_valid_i = 1'b1; tx_data_i = 8'h5A; rx_ready_i = 1'b0;
        sample_en_i = 1'b0; shift_en_i = 1'b0; speed_i = 2'd2; sd_i = 4'hF;
        repeat (2) @(posedge clk_i);
        #1;
        check_all_zero("reset");
        tx_en_i = 1'b0; rx_en_i = 1'b0; tx_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle(2);
        check("idle_ready_o", 32'(ready_o), 32'd0);

        // Std TX only: 0xA5 MSB first on sd_o[0].
        rand_plan();
        run_byte(1'b1, 1'b0, 2'd0, 8'hA5, 0);

        // Quad RX only: nibbles 3 then C.
        sd_plan[0] = 4'h3;
        sd_plan[1] = 4'hC;
        run_byte(1'b0, 1'b1, 2'd2, 8'h00, 0);

        // Dual full duplex: 0x1B out, 2'b10 in on every step.
        for (int i = 0; i < 8; i++) sd_plan[i] = 4'b0010;
        run_byte(1'b1, 1'b1, 2'd1, 8'h1B, 0);

        // Backpressure: RX byte held for 5 cycles with a TX byte waiting.
        rand_plan();
        run_byte(1'b1, 1'b1, 2'd0, 8'($urandom), 5);

        // Clear after 3 of 8 std steps, then 0x81 through cleanly.
        rand_plan();
        rx = 8'h00;
        start_byte(1'b1, 1'b1, 2'd0, 8'hC3);
        do_steps(1'b1, 8'hC3, 1, 0, 3, rx);
        clr_i = 1'b1;
        @(negedge clk_i);
        check("clr_tx_ready_o", 32'(tx_ready_o), 32'd0);
        idle(1);
        clr_i = 1'b0;
        @(negedge clk_i);
        check("after_clr_ready_o", 32'(ready_o), 32'd0);
        check("after_clr_sd_oe_o", 32'(sd_oe_o), 32'd0);
        check("after_clr_rx_valid_o", 32'(rx_valid_o), 32'd0);
        check("after_clr_tx_ready_o", 32'(tx_ready_o), 32'd1);
        idle(1);
        rand_plan();
        run_byte(1'b1, 1'b0, 2'd0, 8'h81, 0);

        // Speed switched to quad mid-byte stays std; the next byte is quad.
        rand_plan();
        rx = 8'h00;
        start_byte(1'b1, 1'b1, 2'd0, 8'h6E);
        speed_i = 2'd0;
        do_steps(1'b1, 8'h6E, 1, 0, 2, rx);
        speed_i = 2'd2;
        do_steps(1'b1, 8'h6E, 1, 2, 8, rx);
        end_byte(1'b1, 1'b1, rx, 0);
        rand_plan();
        run_byte(1'b1, 1'b1, 2'd2, 8'hD4, 0);

        // Async reset mid-byte with enables and strobes still asserted.
        rand_plan();
        rx = 8'h00;
        start_byte(1'b1, 1'b1, 2'd0, 8'hFF);
        do_steps(1'b1, 8'hFF, 1, 0, 3, rx);
        tx_valid_i = 1'b1;
        #2;
        rst_ni = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        tx_valid_i = 1'b0;
        tx_en_i = 1'b0;
        rx_en_i = 1'b0;
        idle(1);
        rand_plan();
        run_byte(1'b1, 1'b1, 2'd3, 8'h96, 1);

        // Randomised bytes across all modes and enable mixes.
        for (int n = 0; n < 60; n++) begin
            te = 1'($urandom);
            re = te ? 1'($urandom) : 1'b1;
            rand_plan();
            run_byte(te, re, 2'($urandom), 8'($urandom), $urandom_range(0, 3));
            idle($urandom_range(0, 2));
        end

        idle(3);
        check("sd_queue_drained", 32'(exp_sd_q.size()), 32'd0);
        check("rx_queue_drained", 32'(exp_rx_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
